led_mode_seq: RTL
=================

// Module: led_mode_seq
// PURPOSE
//   Switch-driven sequencer for the board RGB LEDs, clocked by the 125 MHz PL clock.
//   - Synchronises and debounces SW0/SW1.
//   - SW0 presses step a colour-mode FSM on LD4. SW1 selects blink mode.
//   - Owns every LD4/LD5 colour pin. No other logic drives the LEDs.
// PARAMETERS
//   SYNC_STAGES     2           flip-flop stages per switch synchroniser (>=2)
//   DEBOUNCE_CYC    1_250_000   consecutive cycles a new level must hold (10 ms); >=1
//   BLINK_HALF_CYC  62_500_000  cycles per blink half-period (0.5 s); >=2
// PORTS
//   clk_125   in   1  125 MHz PL clock; all state on its rising edge
//   rst_n     in   1  asynchronous reset, active-low; deassertion synchronous to clk_125
//   sw        in   2  raw slide switches: sw[0]=SW0 (step), sw[1]=SW1 (blink)
//   ld4_r     out  1  LD4 red, active-high, registered
//   ld4_g     out  1  LD4 green, active-high, registered
//   ld4_b     out  1  LD4 blue, active-high, registered
//   ld5_r     out  1  LD5 red, active-high, registered; always 0
//   ld5_g     out  1  LD5 green, active-high, registered; mirrors db[0]
//   ld5_b     out  1  LD5 blue, active-high, registered; mirrors db[1]
// BEHAVIOUR
//   Reset (rst_n=0, takes effect immediately)
//   - All outputs 0, synchronisers 0, db[1:0]=0, debounce counters 0.
//   - FSM=OFF, cyc_col=BLUE, blink counter 0, phase=0.
//   Synchroniser
//   - Per bit, a SYNC_STAGES shift chain; the last stage is s[i].
//   Debounce (per bit)
//   - If s[i]!=db[i], cnt increments; otherwise cnt clears.
//   - When s[i]!=db[i] and cnt==DEBOUNCE_CYC-1: db[i]<=s[i] and cnt<=0.
//   - A glitch shorter than DEBOUNCE_CYC cycles never changes db.
//   Edge detect
//   - db0_q is db[0] delayed one cycle.
//   - step = db[0] & ~db0_q. One pulse per press; release ignored.
//   Blink timer
//   - Free-running counter 0..BLINK_HALF_CYC-1.
//   - On wrap: phase toggles and tick=1 for that one cycle.
//   FSM (advances on step)
//   - OFF -> BLUE -> GREEN -> RED -> CYCLE -> OFF.
//   - Entering CYCLE loads cyc_col=BLUE.
//   - While in CYCLE, each tick rotates cyc_col: BLUE -> GREEN -> RED -> BLUE.
//   - step and tick in the same cycle: step wins; cyc_col reloads BLUE if entering CYCLE.
//   - OFF/BLUE/GREEN/RED ignore tick.
//   Colour and outputs
//   - col = FSM colour (OFF -> none); in CYCLE, col=cyc_col.
//   - Exactly one of r/g/b is set, or none in OFF.
//   - Blink: if db[1]=1 and phase=0, LD4 outputs forced to 0.
//   - All LED outputs registered from col/db/phase. LD5 is unaffected by blink.
//   Latency
//   - sw pin edge to ld5_* change: SYNC_STAGES+DEBOUNCE_CYC+1 cycles.
//   - SW0 press to LD4 colour change: SYNC_STAGES+DEBOUNCE_CYC+2 cycles.
//   Boundaries
//   - Blink counter and phase never stall or reset except on rst_n.
//   - Both switches changing in the same cycle are debounced independently.
//   - rst_n asserted mid-debounce or mid-blink discards all progress.
// TESTING  (bench parameters: SYNC_STAGES=2, DEBOUNCE_CYC=4, BLINK_HALF_CYC=8)
//   1 Reset held, sw=2'b11 -> all six outputs 0. After release: LD4 off until first step.
//   2 sw[0] 0->1 held -> ld5_g=1 after exactly 7 cycles; ld4_b=1 after exactly 8 cycles.
//   3 sw[0] pulsed high 3 cycles, repeated with 1-cycle gaps -> db[0], ld5_g and FSM unchanged.
//   4 Five clean SW0 presses (each held 10 cycles, released 10 cycles):
//     -> LD4 goes b, g, r, then rotates b/g/r every 8 cycles, then off.
//   5 State RED, sw[1]=1 held -> ld5_b=1; ld4_r toggles 8 cycles on / 8 off.
//     Then sw[1]=0 -> ld4_r steady 1.
//   6 rst_n pulsed low 1 cycle while in CYCLE with blink on
//     -> outputs 0 in that same cycle; FSM OFF; blink counter restarts from 0.

Source files
------------

// File: rtl/led_mode_seq.sv
// Switch-driven RGB LED mode sequencer; sw pin to LD5 is SYNC_STAGES+DEBOUNCE_CYC+1 cycles, SW0 to LD4 is +2.
// No backpressure: the LED outputs are free-running registered levels.
module led_mode_seq #(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_CYC   = 1_250_000,
  parameter int BLINK_HALF_CYC = 62_500_000
) (
  input  logic       clk_125,
  input  logic       rst_n,
  input  logic [1:0] sw,
  output logic       ld4_r,
  output logic       ld4_g,
  output logic       ld4_b,
  output logic       ld5_r,
  output logic       ld5_g,
  output logic       ld5_b
);

  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int BW = $clog2(BLINK_HALF_CYC);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYC - 1);

  typedef enum logic [2:0] {ST_OFF, ST_BLUE, ST_GREEN, ST_RED, ST_CYCLE} state_e;
  typedef enum logic [1:0] {COL_NONE, COL_BLUE, COL_GREEN, COL_RED} col_e;

  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][DW-1:0]          cnt_q, cnt_d;
  logic [1:0]                  db_q, db_d;
  logic [1:0]                  s;
  logic                        db0_q;
  logic                        step, tick, blank;
  logic [BW-1:0]               blink_cnt_q, blink_cnt_d;
  logic                        phase_q, phase_d;
  state_e                      state_q, state_d;
  col_e                        cyc_col_q, cyc_col_d, col;
  logic ld4_r_q, ld4_g_q, ld4_b_q, ld5_r_q, ld5_g_q, ld5_b_q;

  always_comb begin
    sync_d = sync_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    s      = '0;
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], sw[i]};
      s[i]      = sync_q[i][SYNC_STAGES-1];
      if (s[i] != db_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          db_d[i]  = s[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign step        = db_q[0] & ~db0_q;
  assign tick        = (blink_cnt_q == BLINK_LAST);
  assign blink_cnt_d = tick ? '0 : blink_cnt_q + 1'b1;
  assign phase_d     = phase_q ^ tick;

  // A step takes priority over a tick; entering CYCLE always restarts on blue.
  always_comb begin
    state_d   = state_q;
    cyc_col_d = cyc_col_q;
    if (step) begin
      case (state_q)
        ST_OFF:   state_d = ST_BLUE;
        ST_BLUE:  state_d = ST_GREEN;
        ST_GREEN: state_d = ST_RED;
        ST_RED: begin
          state_d   = ST_CYCLE;
          cyc_col_d = COL_BLUE;
        end
        default:  state_d = ST_OFF;
      endcase
    end else if (state_q == ST_CYCLE && tick) begin
      case (cyc_col_q)
        COL_BLUE:  cyc_col_d = COL_GREEN;
        COL_GREEN: cyc_col_d = COL_RED;
        default:   cyc_col_d = COL_BLUE;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      ST_BLUE:  col = COL_BLUE;
      ST_GREEN: col = COL_GREEN;
      ST_RED:   col = COL_RED;
      ST_CYCLE: col = cyc_col_q;
      default:  col = COL_NONE;
    endcase
  end

  assign blank = db_q[1] & ~phase_q;

  always_ff @(posedge clk_125 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      db_q        <= '0;
      db0_q       <= 1'b0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      state_q     <= ST_OFF;
      cyc_col_q   <= COL_BLUE;
      ld4_r_q     <= 1'b0;
      ld4_g_q     <= 1'b0;
      ld4_b_q     <= 1'b0;
      ld5_r_q     <= 1'b0;
      ld5_g_q     <= 1'b0;
      ld5_b_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      db_q        <= db_d;
      db0_q       <= db_q[0];
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      state_q     <= state_d;
      cyc_col_q   <= cyc_col_d;
      ld4_r_q     <= (col == COL_RED)   & ~blank;
      ld4_g_q     <= (col == COL_GREEN) & ~blank;
      ld4_b_q     <= (col == COL_BLUE)  & ~blank;
      ld5_r_q     <= 1'b0;
      ld5_g_q     <= db_q[0];
      ld5_b_q     <= db_q[1];
    end
  end

  assign ld4_r = ld4_r_q;
  assign ld4_g = ld4_g_q;
  assign ld4_b = ld4_b_q;
  assign ld5_r = ld5_r_q;
  assign ld5_g = ld5_g_q;
  assign ld5_b = ld5_b_q;

endmodule
